// File: rtl/sd_sector_sched_pkg.sv
// Shared types and defaults for the SD sector read scheduler.
package sd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } sd_state_e;

  localparam logic [23:0]  TIMEOUT_CYCLES_DEF = 24'd10_000_000;
  localparam int unsigned  MAX_RETRY_DEF      = 3;

  localparam int unsigned  ADDR_W  = 32;
  localparam int unsigned  CNT_W   = 8;
  localparam int unsigned  TMO_W   = 24;
  localparam int unsigned  RETRY_W = 8;

endpackage

// File: rtl/sd_sector_sched_arb.sv
// Round-robin grant: priority starts at the requester after 'last'.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant
);

  logic w_found;

  // Scan requesters from last+1 upward (wrapping), first asserted one wins.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!w_found && req[IW'((32'(last) + off) % NUM_REQ)]) begin
        grant[IW'((32'(last) + off) % NUM_REQ)] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_sector_sched.sv
// Arbitrates burst read requests onto a single SD sector reader with retry and timeout.
module sd_sector_sched
  import sd_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_RETRY      = MAX_RETRY_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_addr,
  input  logic [NUM_REQ*8-1:0]       req_count,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [31:0]                sd_addr_out,
  output logic                       sd_read_en_out,
  input  logic                       sd_done_in,
  input  logic                       sd_error_in,
  output logic                       sect_valid_out,
  output logic [7:0]                 sect_index_out,
  output logic [$clog2(NUM_REQ)-1:0] owner_out,
  output logic                       resp_valid_out,
  output logic                       resp_err_out,
  output logic                       busy_out
);

  localparam int unsigned OW = $clog2(NUM_REQ);

  sd_state_e            r_state, w_state_nxt;
  logic [OW-1:0]        r_owner, w_owner_nxt, r_last, w_last_nxt;
  logic [ADDR_W-1:0]    r_base, w_base_nxt, r_sd_addr, w_sd_addr_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt, r_index, w_index_nxt;
  logic [CNT_W-1:0]     r_sect_index, w_sect_index_nxt;
  logic [RETRY_W-1:0]   r_retry, w_retry_nxt;
  logic [TMO_W-1:0]     r_tmo, w_tmo_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_sd_read_en, w_sd_read_en_nxt;
  logic                 r_sect_valid, w_sect_valid_nxt;
  logic                 r_resp_valid, w_resp_valid_nxt;
  logic                 r_resp_err, w_resp_err_nxt;
  logic                 r_busy, w_busy_nxt;

  logic [NUM_REQ-1:0]   w_grant;
  logic [OW-1:0]        w_sel_idx;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [CNT_W-1:0]     w_sel_cnt;
  logic                 w_tmo_hit;
  logic                 w_retry_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .last  (r_last),
    .grant (w_grant)
  );

  // Ready is only offered while idle and out of reset.
  assign req_ready  = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
  assign w_tmo_hit  = (r_tmo == (TIMEOUT_CYCLES - 24'd1));
  assign w_retry_ok = (r_retry < RETRY_W'(MAX_RETRY));

  // Mux the granted requester's address and count.
  always_comb begin
    w_sel_idx  = '0;
    w_sel_addr = '0;
    w_sel_cnt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx  = OW'(i);
        w_sel_addr = req_addr[32*i +: 32];
        w_sel_cnt  = req_count[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_nxt       = r_last;
    w_base_nxt       = r_base;
    w_count_nxt      = r_count;
    w_index_nxt      = r_index;
    w_retry_nxt      = r_retry;
    w_tmo_nxt        = r_tmo;
    w_err_nxt        = r_err;
    w_sect_valid_nxt = 1'b0;
    w_sect_index_nxt = r_sect_index;

    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_owner_nxt = w_sel_idx;
          w_base_nxt  = w_sel_addr;
          w_count_nxt = w_sel_cnt;
          w_index_nxt = '0;
          w_retry_nxt = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = (w_sel_cnt == '0) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_tmo_nxt   = '0;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Error beats done; done beats a simultaneous timeout.
        if (sd_error_in || (!sd_done_in && w_tmo_hit)) begin
          if (w_retry_ok) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_state_nxt = ST_ISSUE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end else if (sd_done_in) begin
          w_sect_valid_nxt = 1'b1;
          w_sect_index_nxt = r_index;
          w_retry_nxt      = '0;
          w_index_nxt      = r_index + 8'd1;
          w_state_nxt      = ((r_index + 8'd1) == r_count) ? ST_RESP : ST_ISSUE;
        end else begin
          w_tmo_nxt = r_tmo + 24'd1;
        end
      end
      ST_RESP: begin
        w_last_nxt  = r_owner;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_sd_read_en_nxt = (w_state_nxt == ST_ISSUE);
    w_sd_addr_nxt    = w_base_nxt + ADDR_W'(w_index_nxt);
    w_resp_valid_nxt = (w_state_nxt == ST_RESP);
    w_resp_err_nxt   = (w_state_nxt == ST_RESP) && w_err_nxt;
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last       <= OW'(NUM_REQ - 1);
      r_base       <= '0;
      r_count      <= '0;
      r_index      <= '0;
      r_retry      <= '0;
      r_tmo        <= '0;
      r_err        <= 1'b0;
      r_sd_addr    <= '0;
      r_sd_read_en <= 1'b0;
      r_sect_valid <= 1'b0;
      r_sect_index <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last       <= w_last_nxt;
      r_base       <= w_base_nxt;
      r_count      <= w_count_nxt;
      r_index      <= w_index_nxt;
      r_retry      <= w_retry_nxt;
      r_tmo        <= w_tmo_nxt;
      r_err        <= w_err_nxt;
      r_sd_addr    <= w_sd_addr_nxt;
      r_sd_read_en <= w_sd_read_en_nxt;
      r_sect_valid <= w_sect_valid_nxt;
      r_sect_index <= w_sect_index_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign sd_addr_out    = r_sd_addr;
  assign sd_read_en_out = r_sd_read_en;
  assign sect_valid_out = r_sect_valid;
  assign sect_index_out = r_sect_index;
  assign owner_out      = r_owner;
  assign resp_valid_out = r_resp_valid;
  assign resp_err_out   = r_resp_err;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_sd_sector_sched.sv
// Directed bench for sd_sector_sched: burst vector table plus arbitration and reset sequences.
module tb_sd_sector_sched;

  localparam int MODE_OK   = 0;  // done after latency
  localparam int MODE_ERR1 = 1;  // error on first start, then done
  localparam int MODE_BOTH = 2;  // done+error on first start, then done
  localparam int MODE_NONE = 3;  // never answers

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  count;
    int          mode;
    int          lat;
    int          exp_starts;
    logic [31:0] exp_addr_first;
    logic [31:0] exp_addr_last;
    int          exp_sects;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [15:0] req_count;
  logic [1:0]  req_ready;
  logic [31:0] sd_addr_out;
  logic        sd_read_en_out;
  logic        sd_done_in  = 1'b0;
  logic        sd_error_in = 1'b0;
  logic        sect_valid_out;
  logic [7:0]  sect_index_out;
  logic [0:0]  owner_out;
  logic        resp_valid_out;
  logic        resp_err_out;
  logic        busy_out;

  int n_total = 0;
  int n_pass  = 0;

  // SD reader model controls
  int sd_mode = MODE_OK;
  int sd_lat  = 5;
  int sd_gen  = 0;
  int sd_gen_seen = 0;
  int sd_cnt  = 0;

  // Monitor logs (append-only)
  logic [31:0] start_q[$];
  logic [7:0]  sect_q[$];
  logic [1:0]  grant_q[$];
  int          resp_cnt = 0;
  logic        resp_err_l = 1'b0;
  logic [0:0]  resp_owner_l = 1'b0;

  vec_t vecs[8];

  sd_sector_sched #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (24'd16),
    .MAX_RETRY      (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_count      (req_count),
    .req_ready      (req_ready),
    .sd_addr_out    (sd_addr_out),
    .sd_read_en_out (sd_read_en_out),
    .sd_done_in     (sd_done_in),
    .sd_error_in    (sd_error_in),
    .sect_valid_out (sect_valid_out),
    .sect_index_out (sect_index_out),
    .owner_out      (owner_out),
    .resp_valid_out (resp_valid_out),
    .resp_err_out   (resp_err_out),
    .busy_out       (busy_out)
  );

  always #5 clk = ~clk;

  // SD reader: answers sd_lat cycles after each start pulse.
  always @(negedge clk) begin
    sd_done_in  = 1'b0;
    sd_error_in = 1'b0;
    if (sd_cnt > 0) begin
      sd_cnt = sd_cnt - 1;
      if (sd_cnt == 0) begin
        if ((sd_mode == MODE_ERR1 || sd_mode == MODE_BOTH) && sd_gen_seen != sd_gen) begin
          sd_error_in = 1'b1;
          sd_done_in  = (sd_mode == MODE_BOTH);
          sd_gen_seen = sd_gen;
        end else begin
          sd_done_in = 1'b1;
        end
      end
    end
    if (sd_read_en_out && sd_mode != MODE_NONE) sd_cnt = sd_lat;
  end

  // Output monitor
  always @(negedge clk) begin
    if (sd_read_en_out) start_q.push_back(sd_addr_out);
    if (sect_valid_out) sect_q.push_back(sect_index_out);
    if (resp_valid_out) begin
      resp_cnt     = resp_cnt + 1;
      resp_err_l   = resp_err_out;
      resp_owner_l = owner_out;
    end
    if (|(req_ready & req_valid)) grant_q.push_back(req_ready & req_valid);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {16'd0, req_ready, sd_addr_out, sd_read_en_out, sect_valid_out,
            sect_index_out, owner_out, resp_valid_out, resp_err_out, busy_out};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_resp(input int r0, input string name);
    int cyc = 0;
    while (resp_cnt == r0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (resp_cnt == r0) $display("FAIL %s_timeout: got no response, expected resp_valid within 3000 cycles", name);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int s0, k0, r0, cyc, nbad;
    bit acc;
    s0 = start_q.size(); k0 = sect_q.size(); r0 = resp_cnt;
    sd_mode = v.mode; sd_lat = v.lat; sd_gen++;
    @(posedge clk); #1;
    req_addr[31:0]  = v.addr;
    req_count[7:0]  = v.count;
    req_valid       = 2'b01;
    acc = 1'b0;
    for (cyc = 0; cyc < 50 && !acc; cyc++) begin
      @(negedge clk);
      if (req_ready[0]) acc = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk($sformatf("v%0d_accept", vi), 64'(acc), 64'd1);
    wait_resp(r0, $sformatf("v%0d", vi));
    chk($sformatf("v%0d_resp_count", vi), 64'(resp_cnt - r0), 64'd1);
    chk($sformatf("v%0d_starts", vi), 64'(start_q.size() - s0), 64'(v.exp_starts));
    if (v.exp_starts > 0 && start_q.size() > s0) begin
      chk($sformatf("v%0d_addr_first", vi), 64'(start_q[s0]), 64'(v.exp_addr_first));
      chk($sformatf("v%0d_addr_last", vi), 64'(start_q[start_q.size()-1]), 64'(v.exp_addr_last));
    end
    chk($sformatf("v%0d_sects", vi), 64'(sect_q.size() - k0), 64'(v.exp_sects));
    nbad = 0;
    for (int i = 0; i < sect_q.size() - k0; i++)
      if (sect_q[k0+i] != 8'(i)) nbad++;
    chk($sformatf("v%0d_sect_index_seq_bad", vi), 64'(nbad), 64'd0);
    chk($sformatf("v%0d_resp_err", vi), 64'(resp_err_l), 64'(v.exp_err));
    chk($sformatf("v%0d_owner", vi), 64'(resp_owner_l), 64'd0);
  endtask

  initial begin
    int g0, s0, r0, cyc;
    logic [1:0] exp_g;

    //          addr           cnt    mode       lat starts first          last           sects err
    vecs[0] = '{32'h0000_0100, 8'd3,   MODE_OK,   5,  3,   32'h0000_0100, 32'h0000_0102, 3,   1'b0};
    vecs[1] = '{32'h0000_0020, 8'd1,   MODE_ERR1, 5,  2,   32'h0000_0020, 32'h0000_0020, 1,   1'b0};
    vecs[2] = '{32'h0000_0030, 8'd1,   MODE_BOTH, 5,  2,   32'h0000_0030, 32'h0000_0030, 1,   1'b0};
    vecs[3] = '{32'h0000_0040, 8'd1,   MODE_NONE, 5,  4,   32'h0000_0040, 32'h0000_0040, 0,   1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 8'd2,   MODE_OK,   5,  2,   32'hFFFF_FFFF, 32'h0000_0000, 2,   1'b0};
    vecs[5] = '{32'h0000_0500, 8'd0,   MODE_OK,   5,  0,   32'h0,         32'h0,         0,   1'b0};
    vecs[6] = '{32'h0000_0600, 8'd1,   MODE_OK,   16, 1,   32'h0000_0600, 32'h0000_0600, 1,   1'b0};
    vecs[7] = '{32'h0000_0010, 8'd255, MODE_OK,   2,  255, 32'h0000_0010, 32'h0000_010E, 255, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_addr  = '0;
    req_count = {8'd1, 8'd1};
    #23;
    chk("reset_outputs", all_outs(), 64'd0);
    req_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_not_busy", 64'(busy_out), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Two held requesters from reset must alternate grants.
    do_reset();
    sd_mode = MODE_OK; sd_lat = 5;
    g0 = grant_q.size();
    req_addr  = {32'h0000_2000, 32'h0000_1000};
    req_count = {8'd1, 8'd1};
    @(posedge clk); #1 req_valid = 2'b11;
    cyc = 0;
    while (grant_q.size() < g0 + 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1 req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      if (grant_q.size() > g0 + i)
        chk($sformatf("rr_grant%0d", i), 64'(grant_q[g0+i]), 64'(exp_g));
      else
        chk($sformatf("rr_grant%0d_missing", i), 64'(grant_q.size() - g0), 64'(i + 1));
    end
    cyc = 0;
    while (busy_out && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rr_idle_after", 64'(busy_out), 64'd0);

    // Reset during WAIT_DONE drops the burst and restores requester-0 priority.
    do_reset();
    r0 = resp_cnt;
    @(posedge clk); #1 req_valid = 2'b01;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_resp(r0, "pre_burst");
    sd_mode = MODE_NONE;
    @(posedge clk); #1 req_valid = 2'b10;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", 64'(busy_out), 64'd1);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    s0 = start_q.size(); r0 = resp_cnt;
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("dropped_no_resp", 64'(resp_cnt - r0), 64'd0);
    chk("dropped_no_start", 64'(start_q.size() - s0), 64'd0);
    sd_mode = MODE_OK;
    g0 = grant_q.size();
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 2'b00;
    if (grant_q.size() > g0)
      chk("post_reset_grant", 64'(grant_q[g0]), 64'd1);
    else
      chk("post_reset_grant_missing", 64'(grant_q.size() - g0), 64'd1);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_sector_sched.md
SD_SECTOR_SCHED -- requirements
Module: sd_sector_sched

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the SD read path.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd10_000_000: cycles allowed in WAIT_DONE before a read is declared failed.
REQ-003 Parameter MAX_RETRY, default 3: reissues allowed per sector after the first attempt.
REQ-004 Ports: clk  in  1  system clock; all state advances on its rising edge.
REQ-005 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Ports: req_valid  in  NUM_REQ  per-requester request strobe, held until accepted.
REQ-007 Ports: req_addr  in  NUM_REQ*32  per-requester first sector address, requester i at bits [32i +: 32].
REQ-008 Ports: req_count  in  NUM_REQ*8  per-requester sector count, requester i at bits [8i +: 8].
REQ-009 Ports: req_ready  out  NUM_REQ  one-hot accept; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 Ports: sd_addr_out  out  32  sector address presented to the SD reader.
REQ-011 Ports: sd_read_en_out  out  1  one-cycle start pulse to the SD reader.
REQ-012 Ports: sd_done_in  in  1  SD reader completion; sampled only in WAIT_DONE.
REQ-013 Ports: sd_error_in  in  1  SD reader failure; sampled only in WAIT_DONE.
REQ-014 Ports: sect_valid_out  out  1  one-cycle pulse per successfully read sector.
REQ-015 Ports: sect_index_out  out  8  zero-based index of that sector within the burst.
REQ-016 Ports: owner_out  out  $clog2(NUM_REQ)  requester index of the current burst.
REQ-017 Ports: resp_valid_out  out  1  one-cycle burst-complete pulse; owner_out is valid with it.
REQ-018 Ports: resp_err_out  out  1  qualifies resp_valid_out; 1 means the burst was aborted.
REQ-019 Ports: busy_out  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL implement these states: IDLE, ISSUE, WAIT_DONE, RESP.
REQ-021 IDLE: req_ready SHALL be a round-robin grant over req_valid, combinational within the cycle; priority starts at the requester after the last granted one.
- Acceptance latches the owner, base address and count, and clears the index and retry counter.
- The next state is ISSUE, or RESP with err=0 if the count is 0.
REQ-022 ISSUE: sd_addr_out SHALL equal base+index, truncated to 32 bits (wraps modulo 2^32).
- sd_read_en_out is high for exactly this one cycle.
- The timeout counter clears, and the next state is WAIT_DONE.
REQ-023 WAIT_DONE, sd_done_in=1: sect_valid_out SHALL pulse the next cycle with the current index.
- The retry counter clears and the index increments.
- The next state is RESP if index+1 equals count, otherwise ISSUE.
REQ-024 WAIT_DONE, sd_error_in=1 or timeout reached: if retry<MAX_RETRY, the FSM SHALL increment retry and return to ISSUE with the same address.
- Otherwise it SHALL go to RESP with err=1.
REQ-025 If sd_done_in and sd_error_in are high in the same cycle, error SHALL win.
REQ-026 If sd_done_in arrives in the same cycle the timeout count is reached, done SHALL win.
REQ-027 RESP: resp_valid_out SHALL pulse for one cycle with resp_err_out, and the next state SHALL be IDLE.
- The round-robin pointer updates to the owner.
REQ-028 req_ready SHALL be all-zero outside IDLE; requests arriving while busy stay pending.
REQ-029 Minimum cycles per sector SHALL be 2 plus the SD reader's latency; burst overhead is 1 accept cycle plus 1 RESP cycle.
REQ-030 req_count=255 SHALL read 255 sectors; the index SHALL never wrap within a burst.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE and all outputs 0.
- Counters and pointer clear; the pointer favours requester 0 first.
REQ-032 Reset mid-burst SHALL drop the burst with no response pulse, and sd_read_en_out SHALL be 0 from reset assertion.

Structure
REQ-033 Package sd_sched_pkg SHALL hold the state enum and the default TIMEOUT_CYCLES and MAX_RETRY constants.
REQ-034 Round-robin grant logic SHALL be the sub-module rr_arbiter (NUM_REQ, req, last, grant).

Verification
REQ-035 Single burst test SHALL cover both requests and responses:
- Stimulus: req0 addr=0x100, count=3; SD returns done 5 cycles after each start.
- Response: three sd_read_en_out pulses at addresses 0x100, 0x101, 0x102; sect_index 0, 1, 2; resp_valid with err=0 and owner 0.
REQ-036 Both requesters valid from reset with count=1 each, held: grants SHALL go req0, req1, req0, alternating, never the same requester twice in a row.
REQ-037 A first-attempt sd_error_in then done on address 0x20 SHALL produce two pulses on 0x20, one sect_valid pulse, and err=0.
REQ-038 With TIMEOUT_CYCLES=16, MAX_RETRY=3 and no done: exactly 4 start pulses, then resp err=1 at owner; sect_valid never pulses.
REQ-039 Wrap and zero-count boundaries:
- Stimulus: addr=0xFFFF_FFFF with count=2, then a request with count=0.
- Response: addresses 0xFFFF_FFFF then 0x0000_0000; the count=0 request gives a resp pulse with err=0 and no sd_read_en_out.
REQ-040 rst_n pulsed low during WAIT_DONE: all outputs 0 immediately, no resp pulse, next accept goes to requester 0.
